// File: rtl/peri_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// peri_pkg : shared state type and widths for the peri-row MAC sequencer
// Rev 1.0
// -----------------------------------------------------------------------------
package peri_pkg;

  localparam int NUM_SLICES  = 4;
  localparam int SLICE_IDX_W = 2;
  localparam int ACC_W       = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACC   = 3'd3,
    ST_DONE  = 3'd4,
    ST_FLUSH = 3'd5
  } mac_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/peri_row_mac_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// peri_row_mac_seq : steps four 2-bit slices through the array, accumulates the
//                    shifted partial sums and keeps the shifter counter aligned
// Rev 1.0
// -----------------------------------------------------------------------------
module peri_row_mac_seq
  import peri_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_valid_i,
  output logic                   start_ready_o,
  input  logic                   abort_i,
  output logic                   rd_en_o,
  output logic [SLICE_IDX_W-1:0] slice_idx_o,
  output logic                   shift_counter_en_o,
  input  logic [ACC_W-1:0]       shifter_output_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [ACC_W-1:0]       result_o,
  output logic                   busy_o
);

  localparam int                     LAT_W      = 3;
  localparam logic [SLICE_IDX_W-1:0] LAST_SLICE = SLICE_IDX_W'(NUM_SLICES - 1);
  localparam logic [LAT_W-1:0]       LAT_LOAD   = (READ_LAT > 0) ? LAT_W'(READ_LAT - 1) : '0;

  mac_seq_state_e         state;
  logic [SLICE_IDX_W-1:0] shadow;
  logic [LAT_W-1:0]       lat_cnt;
  logic [ACC_W-1:0]       acc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      shadow  <= '0;
      lat_cnt <= '0;
      acc     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid_i) begin
            acc   <= '0;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort_i) begin
            state <= ST_FLUSH;
          end else if (READ_LAT > 0) begin
            lat_cnt <= LAT_LOAD;
            state   <= ST_WAIT;
          end else begin
            state <= ST_ACC;
          end
        end
        ST_WAIT: begin
          if (abort_i) begin
            state <= ST_FLUSH;
          end else if (lat_cnt == '0) begin
            state <= ST_ACC;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_ACC: begin
          // An abort here still lets this slice's pulse and accumulate complete.
          acc    <= acc + shifter_output_i;
          shadow <= shadow + 1'b1;
          if (shadow == LAST_SLICE) begin
            state <= abort_i ? ST_IDLE : ST_DONE;
          end else begin
            state <= abort_i ? ST_FLUSH : ST_ISSUE;
          end
        end
        ST_DONE: begin
          if (result_ready_i) begin
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          // The shifter counter has no clear, so pulse it round to zero.
          shadow <= shadow + 1'b1;
          if (shadow == LAST_SLICE) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign start_ready_o      = (state == ST_IDLE);
  assign busy_o             = (state != ST_IDLE);
  assign rd_en_o            = (state == ST_ISSUE);
  assign shift_counter_en_o = (state == ST_ACC) || (state == ST_FLUSH);
  assign result_valid_o     = (state == ST_DONE);
  assign slice_idx_o        = shadow;
  assign result_o           = acc;

endmodule
`default_nettype wire

// File: tb/tb_peri_row_mac_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_peri_row_mac_seq : directed vectors with a result scoreboard and a shifter
//                       model that owns its own free-running shift counter
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_peri_row_mac_seq;

  localparam int LAT = 1;

  typedef struct {
    logic [19:0] res;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        abort = 1'b0;
  logic        result_ready = 1'b1;
  logic        start_ready, rd_en, shift_en, result_valid, busy;
  logic [1:0]  slice_idx;
  logic [19:0] shifter_output, result;

  logic        start_valid0 = 1'b0;
  logic        abort0 = 1'b0;
  logic        result_ready0 = 1'b1;
  logic        start_ready0, rd_en0, shift_en0, result_valid0, busy0;
  logic [1:0]  slice_idx0;
  logic [19:0] shifter_output0, result0;

  logic [19:0] enc_sum [4];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          pulses = 0;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  peri_row_mac_seq #(.READ_LAT(LAT)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_valid_i(start_valid), .start_ready_o(start_ready),
    .abort_i(abort), .rd_en_o(rd_en), .slice_idx_o(slice_idx), .shift_counter_en_o(shift_en),
    .shifter_output_i(shifter_output), .result_valid_o(result_valid),
    .result_ready_i(result_ready), .result_o(result), .busy_o(busy)
  );

  peri_row_mac_seq #(.READ_LAT(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_valid_i(start_valid0), .start_ready_o(start_ready0),
    .abort_i(abort0), .rd_en_o(rd_en0), .slice_idx_o(slice_idx0), .shift_counter_en_o(shift_en0),
    .shifter_output_i(shifter_output0), .result_valid_o(result_valid0),
    .result_ready_i(result_ready0), .result_o(result0), .busy_o(busy0)
  );

  // Shifter model: data valid READ_LAT+1 cycles after the read, shifted by its own counter.
  logic       pv [LAT+1];
  logic [1:0] ps [LAT+1];
  logic [1:0] shcnt;
  logic       pv0;
  logic [1:0] ps0, shcnt0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LAT; i++) begin pv[i] <= 1'b0; ps[i] <= 2'd0; end
      shcnt <= 2'd0; pv0 <= 1'b0; ps0 <= 2'd0; shcnt0 <= 2'd0;
    end else begin
      pv[0] <= rd_en; ps[0] <= slice_idx;
      for (int i = 1; i <= LAT; i++) begin pv[i] <= pv[i-1]; ps[i] <= ps[i-1]; end
      if (shift_en) shcnt <= shcnt + 2'd1;
      pv0 <= rd_en0; ps0 <= slice_idx0;
      if (shift_en0) shcnt0 <= shcnt0 + 2'd1;
    end
  end

  assign shifter_output  = pv[LAT] ? (enc_sum[ps[LAT]] << {shcnt, 1'b0}) : 20'h5A5A5;
  assign shifter_output0 = pv0 ? (enc_sum[ps0] << {shcnt0, 1'b0}) : 20'h5A5A5;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t item;
    if (shift_en) pulses++;
    if (start_valid && start_ready) start_cyc = cyc;
    if (result_valid && !prev_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("valid_latency", cyc - start_cyc, sb[0].lat);
    end
    if (result_valid && result_ready && sb.size() > 0) begin
      item = sb.pop_front();
      chk("result", result, item.res);
    end
    prev_valid = result_valid;
  end

  function automatic logic [19:0] enc(input int l0, input int l1, input int l2, input int l3);
    return 20'(64 * l0 + 16 * l1 + 4 * l2 + l3);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_enc(input logic [19:0] e0, input logic [19:0] e1,
                         input logic [19:0] e2, input logic [19:0] e3);
    enc_sum[0] = e0; enc_sum[1] = e1; enc_sum[2] = e2; enc_sum[3] = e3;
  endtask

  task automatic start(input logic with_abort);
    start_valid = 1'b1; abort = with_abort;
    tick();
    start_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (start_ready) break;
      n++;
    end
    if (n >= 200) chk("idle_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_issue(input logic [1:0] k);
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (rd_en && slice_idx == k) break;
      n++;
    end
    if (n >= 100) chk("issue_timeout", 0, 1);
  endtask

  task automatic run_op(input string name, input logic [19:0] exp, input logic with_abort);
    int mark;
    sb.push_back('{res: exp, lat: 4 * (LAT + 2) + 1});
    start(with_abort);
    mark = pulses;
    wait_idle();
    chk({name, "_pulses"}, pulses - mark, 4);
  endtask

  // Abort in ACC of slice k (acc_case) or in WAIT of slice k; returns flush pulses seen.
  task automatic abort_op(input logic [1:0] k, input logic acc_case, output int flush);
    int mark, opmark;
    start(1'b0);
    opmark = pulses;
    wait_issue(k);
    tick();
    if (acc_case) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    mark = pulses;
    wait_idle();
    flush = pulses - mark;
    chk("abort_total_pulses", pulses - opmark, 4);
  endtask

  initial begin
    int flush, pmark, n;
    logic [19:0] held;
    set_enc(20'd0, 20'd0, 20'd0, 20'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_outs", {start_ready, busy, rd_en, shift_en, result_valid, slice_idx, result},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 20'd0});
    tick();

    set_enc(20'd10795, 20'd10795, 20'd10795, 20'd10795);
    run_op("full_scale", 20'd917575, 1'b0);

    set_enc(enc(1, 0, 0, 0), 20'd0, 20'd0, 20'd0);
    run_op("bit_slice0", 20'd64, 1'b0);
    set_enc(20'd0, 20'd0, 20'd0, enc(1, 0, 0, 0));
    run_op("bit_slice3", 20'd4096, 1'b0);

    // Start and abort together in IDLE: start wins.
    set_enc(enc(1, 0, 0, 0), 20'd0, 20'd0, 20'd0);
    run_op("start_with_abort", 20'd64, 1'b1);

    // Backpressure
    set_enc(enc(0, 5, 0, 0), enc(0, 0, 0, 7), enc(0, 0, 3, 0), enc(2, 0, 0, 0));
    result_ready = 1'b0;
    sb.push_back('{res: 20'd8492, lat: 4 * (LAT + 2) + 1});
    start(1'b0);
    n = 0;
    while (n < 100 && !result_valid) begin @(negedge clk); n++; end
    chk("bp_valid_seen", result_valid, 1);
    tick();
    held = result;
    pmark = pulses;
    chk("bp_result_value", held, 20'd8492);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable", {result_valid, start_ready, result}, {1'b1, 1'b0, held});
    end
    chk("bp_no_pulses", pulses - pmark, 0);
    result_ready = 1'b1;
    wait_idle();

    // Abort in WAIT of slice 1, then an op that needs the shifter realigned.
    set_enc(20'd10795, 20'd10795, 20'd10795, 20'd10795);
    abort_op(2'd1, 1'b0, flush);
    chk("abort_wait_s1_flush", flush, 3);
    set_enc(enc(0, 5, 0, 0), enc(0, 0, 0, 7), enc(0, 0, 3, 0), enc(2, 0, 0, 0));
    run_op("after_abort", 20'd8492, 1'b0);

    abort_op(2'd3, 1'b1, flush);
    chk("abort_acc_s3_flush", flush, 0);
    abort_op(2'd1, 1'b1, flush);
    chk("abort_acc_s1_flush", flush, 2);

    // Reset in ACC of slice 1
    set_enc(20'd10795, 20'd10795, 20'd10795, 20'd10795);
    sb.push_back('{res: 20'd0, lat: 0});
    start(1'b0);
    wait_issue(2'd1);
    tick();
    tick();
    chk("in_acc_before_reset", shift_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", {start_ready, busy, rd_en, shift_en, result_valid, slice_idx, result},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 20'd0});
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("after_reset", 20'd917575, 1'b0);

    // READ_LAT = 0 instance
    start_valid0 = 1'b1;
    tick();
    start_valid0 = 1'b0;
    n = 1;
    while (n < 60) begin
      @(negedge clk);
      if (result_valid0) break;
      n++;
    end
    chk("lat0_valid_cycle", n, 9);
    chk("lat0_result", result0, 20'd917575);
    tick();
    tick();
    chk("lat0_idle", start_ready0, 1);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/peri_row_mac_seq.md
# peri_row_mac_seq

Sequencer for the peri-row bit-serial MAC path. Per operation it steps the array through four 2-bit input slices, waits out the array/encoder read latency, and pulses the shifter's shift-counter enable. It accumulates the 20-bit shifted partial sums into one result and returns it over a valid/ready handshake. It also keeps the shifter's free-running 2-bit shift counter aligned: that counter has no clear, so this block tracks a shadow copy and re-aligns it on abort.

## Interface
- READ_LAT, default 1: cycles from `rd_en_o` until `shifter_output_i` is valid; legal range 0..7.
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- start_valid_i  in  1  operation request
- start_ready_o  out  1  high only in IDLE
- abort_i  in  1  cancel the in-flight operation; no result is produced
- rd_en_o  out  1  one-cycle array read strobe for the current slice
- slice_idx_o  out  2  current slice; equals the shadow shift counter
- shift_counter_en_o  out  1  to the shifter; one pulse per consumed slice
- shifter_output_i  in  20  shifted partial sum from the shifter
- result_valid_o  out  1  result available
- result_ready_i  in  1  consumer accepts the result
- result_o  out  20  accumulated result
- busy_o  out  1  high whenever state is not IDLE

## Operation
- States and transitions:
  - IDLE: if `start_valid_i`, clear acc, go to ISSUE.
  - ISSUE: `rd_en_o`=1. Go to WAIT if READ_LAT>0, else to ACC.
  - WAIT: count READ_LAT cycles, then go to ACC.
  - ACC: acc <= acc + `shifter_output_i`; pulse `shift_counter_en_o`; shadow <= shadow+1.
    - If shadow was 3: go to DONE.
    - Else: go to ISSUE.
  - DONE: `result_valid_o`=1. Go to IDLE on `result_ready_i`.
  - FLUSH: pulse `shift_counter_en_o` every cycle. Go to IDLE in the cycle the shadow wraps to 0.
- Slice order is 0,1,2,3. Shadow 0 applies shift 0, so slice 0 is the LSB pair.
- Width: the maximum shifter sum is 10795×85 = 917575 < 2^20. The 20-bit acc therefore cannot overflow; no saturation logic.
- `result_o` = acc, held stable while `result_valid_o` is high.
- Abort:
  - In ISSUE or WAIT: any pending read is dropped and the next state is FLUSH. Flush lasts 4−shadow cycles.
  - In ACC: that cycle's pulse and accumulate still complete. If the new shadow is 0, go to IDLE; else go to FLUSH.
  - In IDLE or DONE: ignored.
- Simultaneous `start_valid_i` and `abort_i` in IDLE: start accepted, abort ignored.
- `start_valid_i` outside IDLE: not accepted, because `start_ready_o`=0.

## Timing
- Reset values: state IDLE, shadow 0, acc 0. All outputs 0 except `start_ready_o`=1.
- Handshake accepted in cycle 0. Slice k: ISSUE in cycle 1+k(READ_LAT+2); ACC in cycle (k+1)(READ_LAT+2).
- `result_valid_o` rises in cycle 4(READ_LAT+2)+1, i.e. cycle 13 at default.
- Result transfers when `result_valid_o` and `result_ready_i` are both high. `start_ready_o` rises the following cycle. No result-to-start bypass.
- Exactly 4 `shift_counter_en_o` pulses per operation, completed or aborted.
- Reset mid-operation returns the block to its reset state immediately. The shifter shares `rst_ni`, so alignment holds.

## Structure
- Shared package `peri_pkg`:
  - State enum `mac_seq_state_e`.
  - `NUM_SLICES`=4, `SLICE_IDX_W`=2, `ACC_W`=20.
- Single module. The shadow counter, latency counter and acc stay inline; no sub-module.

## Test plan
- Full scale: encoder outputs 127 on all four lanes, every slice, READ_LAT=1 → `result_o`=917575 (0xE0047); `result_valid_o` in cycle 13; 4 enable pulses.
- Single bit: lane 0 = 1 in slice 0, all other inputs 0 → shifter 64, `result_o`=64. Repeat with the value in slice 3 → 4096.
- Backpressure: hold `result_ready_i`=0 for 10 cycles → `result_o` stable, `start_ready_o`=0, no extra enable pulses.
- Abort in WAIT of slice 1 → exactly 3 FLUSH pulses, no `result_valid_o`. The next operation's slice 0 sees the shifter counter at 0, giving a correct result.
- Abort in ACC of slice 3 → straight to IDLE, 0 flush pulses. Abort in ACC of slice 1 → 2 flush pulses.
- Reset asserted mid-ACC → all outputs at reset values. A following full-scale op returns 917575.
- READ_LAT=0 → WAIT skipped; `result_valid_o` in cycle 9.
